fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline: owns the program counter, drives the word address into the combinational `instruction_mem`, and captures the returned word into the IF/ID pipeline register for decode. It handles stall hold, branch/jump redirect with bubble insertion, and fetch-fault detection with a halt state. A retired-fetch counter supports bring-up and performance checks.

---
 rtl/rv_pipe_pkg.sv | 25 ++
 rtl/if_id_reg.sv | 28 ++
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: NOP encoding, fetch fault causes, fetch FSM states
// and the IF/ID register payload shared with decode.
package rv_pipe_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'b00,
      FAULT_MISALIGN = 2'b01,
      FAULT_RANGE    = 2'b10
   } fault_cause_t;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc_plus4;
   } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, bubble and hold controls.
// A bubble clears valid and forces NOP but keeps pc/pc_plus4 for debug visibility.
module if_id_reg
   import rv_pipe_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  logic   bubble,
   input  if_id_t d,
   output if_id_t q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q.valid    <= 1'b0;
         q.pc       <= '0;
         q.instr    <= NOP_INSTR;
         q.pc_plus4 <= '0;
      end else if (bubble) begin
         q.valid <= 1'b0;
         q.instr <= NOP_INSTR;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, fetch fault detection
// with a sticky HALT state, IF/ID capture and a retired-fetch counter.
module fetch_stage
   import rv_pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned IMEM_DEPTH = 64
)(
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc_plus4,
   output logic        halted,
   output logic [1:0]  fault_cause,
   output logic [31:0] fetch_count
);

   fetch_state_t state_q, state_next;
   fault_cause_t cause_q, cause_next;
   logic [31:0]  pc_q, pc_next;
   logic [31:0]  count_q;
   logic         count_inc;
   logic         ifid_load, ifid_bubble;
   logic [31:0]  pc_plus4;
   logic [31:0]  word_idx;
   logic         misaligned, out_of_range;
   if_id_t       ifid_d, ifid_q;

   assign pc_plus4     = pc_q + 32'd4;
   assign word_idx     = {2'b00, pc_q[31:2]};
   assign misaligned   = (pc_q[1:0] != 2'b00);
   assign out_of_range = (word_idx >= IMEM_DEPTH);

   always_comb begin
      ifid_d.valid    = 1'b1;
      ifid_d.pc       = pc_q;
      ifid_d.instr    = imem_rdata;
      ifid_d.pc_plus4 = pc_plus4;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         cause_q <= FAULT_NONE;
         pc_q    <= RESET_PC;
         count_q <= '0;
      end else begin
         state_q <= state_next;
         cause_q <= cause_next;
         pc_q    <= pc_next;
         if (count_inc) count_q <= count_q + 32'd1;
      end
   end

   // Redirect outranks both stall and the fault check; the new PC is checked next cycle.
   always_comb begin
      state_next  = state_q;
      cause_next  = cause_q;
      pc_next     = pc_q;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      count_inc   = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (redirect_valid) begin
               pc_next     = redirect_target;
               ifid_bubble = 1'b1;
            end else if (stall) begin
               pc_next = pc_q;
            end else if (misaligned || out_of_range) begin
               ifid_bubble = 1'b1;
               state_next  = ST_HALT;
               cause_next  = misaligned ? FAULT_MISALIGN : FAULT_RANGE;
            end else begin
               pc_next   = pc_plus4;
               ifid_load = 1'b1;
               count_inc = 1'b1;
            end
         end
         ST_HALT: begin
            ifid_bubble = 1'b1;
         end
         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   if_id_reg u_if_id_reg (
      .clk    (clk),
      .rst    (rst),
      .load   (ifid_load),
      .bubble (ifid_bubble),
      .d      (ifid_d),
      .q      (ifid_q)
   );

   assign imem_addr      = pc_q;
   assign if_id_valid    = ifid_q.valid;
   assign if_id_pc       = ifid_q.pc;
   assign if_id_instr    = ifid_q.instr;
   assign if_id_pc_plus4 = ifid_q.pc_plus4;
   assign halted         = (state_q == ST_HALT);
   assign fault_cause    = cause_q;
   assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a cycle-level reference model produces the
// expected post-edge view of every output; a monitor compares after each edge.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int unsigned DEPTH = 64;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc_plus4;
   logic        halted;
   logic [1:0]  fault_cause;
   logic [31:0] fetch_count;

   fetch_stage #(
      .RESET_PC   (32'h0000_0000),
      .IMEM_DEPTH (DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .if_id_valid     (if_id_valid),
      .if_id_pc        (if_id_pc),
      .if_id_instr     (if_id_instr),
      .if_id_pc_plus4  (if_id_pc_plus4),
      .halted          (halted),
      .fault_cause     (fault_cause),
      .fetch_count     (fetch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] mem [DEPTH];

   // Behavioural instruction memory; out-of-range addresses return a recognisable garbage word.
   always_comb begin
      if ((imem_addr / 4) < DEPTH) imem_rdata = mem[imem_addr / 4];
      else                          imem_rdata = 32'hBAD0_0000 ^ imem_addr;
   end

   typedef struct {
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc_plus4;
      logic        halted;
      logic [1:0]  cause;
      logic [31:0] count;
   } expect_t;

   expect_t sb[$];
   int checks   = 0;
   int failures = 0;

   // Reference model state: what the stage should look like after the next edge.
   logic [31:0] m_pc, m_ipc, m_instr, m_p4, m_cnt;
   logic        m_v, m_halt;
   logic [1:0]  m_cause;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always begin
      expect_t e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("imem_addr",      imem_addr,              e.addr);
         chk("if_id_valid",    {31'd0, if_id_valid},   {31'd0, e.valid});
         chk("if_id_pc",       if_id_pc,               e.pc);
         chk("if_id_instr",    if_id_instr,            e.instr);
         chk("if_id_pc_plus4", if_id_pc_plus4,         e.pc_plus4);
         chk("halted",         {31'd0, halted},        {31'd0, e.halted});
         chk("fault_cause",    {30'd0, fault_cause},   {30'd0, e.cause});
         chk("fetch_count",    fetch_count,            e.count);
      end
   end

   // Apply one cycle of inputs, advance the model by the fetch rules, queue the expectation.
   task automatic cycle(input logic r, input logic s, input logic rv, input logic [31:0] tgt);
      expect_t e;
      @(negedge clk);
      rst = r; stall = s; redirect_valid = rv; redirect_target = tgt;
      if (r) begin
         m_pc = 32'd0; m_v = 1'b0; m_ipc = 32'd0; m_instr = NOP; m_p4 = 32'd0;
         m_halt = 1'b0; m_cause = 2'd0; m_cnt = 32'd0;
      end else if (!m_halt) begin
         if (rv) begin
            m_pc = tgt; m_v = 1'b0; m_instr = NOP;
         end else if (s) begin
            // everything holds
         end else if (m_pc % 4 != 0) begin
            m_halt = 1'b1; m_cause = 2'd1; m_v = 1'b0; m_instr = NOP;
         end else if (m_pc / 4 >= DEPTH) begin
            m_halt = 1'b1; m_cause = 2'd2; m_v = 1'b0; m_instr = NOP;
         end else begin
            m_v = 1'b1; m_ipc = m_pc; m_instr = mem[m_pc / 4]; m_p4 = m_pc + 4;
            m_pc = m_pc + 4; m_cnt = m_cnt + 1;
         end
      end
      e.addr = m_pc; e.valid = m_v; e.pc = m_ipc; e.instr = m_instr; e.pc_plus4 = m_p4;
      e.halted = m_halt; e.cause = m_cause; e.count = m_cnt;
      sb.push_back(e);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'd0);
   endtask

   initial begin
      int wait_cycles;
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
      mem[0] = 32'hfe01_0113;
      mem[1] = 32'h0081_2e23;
      mem[2] = 32'h0201_0413;

      // Directed walk through the bring-up scenarios.
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      run(3);
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      run(2);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 32'd0);
      run(1);
      cycle(1'b0, 1'b1, 1'b1, 32'h38);
      run(2);
      cycle(1'b0, 1'b0, 1'b1, 32'h3A);
      run(2);
      cycle(1'b0, 1'b0, 1'b1, 32'h10);
      cycle(1'b0, 1'b1, 1'b1, 32'h20);
      cycle(1'b1, 1'b0, 1'b1, 32'h40);
      cycle(1'b0, 1'b0, 1'b1, 32'hF0);
      run(6);
      cycle(1'b0, 1'b0, 1'b1, 32'h8);
      cycle(1'b0, 1'b0, 1'b1, 32'h4);
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
      cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      run(2);
      cycle(1'b1, 1'b0, 1'b0, 32'd0);

      // Randomised traffic; mostly legal targets with occasional faults and resets.
      for (int i = 0; i < 600; i++) begin
         logic        r, s, rv;
         logic [31:0] tgt;
         int unsigned sel;
         r  = m_halt ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 99) == 0);
         s  = ($urandom_range(0, 9) < 3);
         rv = ($urandom_range(0, 19) < 3);
         sel = $urandom_range(0, 9);
         if (sel < 6)       tgt = {24'd0, $urandom_range(0, DEPTH - 1), 2'b00} & 32'h0000_00FC;
         else if (sel < 8)  tgt = 32'h0000_00F0 + 32'($urandom_range(0, 3) * 4);
         else if (sel < 9)  tgt = {$urandom} & 32'hFFFF_FFFF;
         else               tgt = 32'h0000_0040 | 32'($urandom_range(1, 3));
         cycle(r, s, rv, tgt);
      end

      @(negedge clk);
      rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
      wait_cycles = 0;
      while (sb.size() > 0 && wait_cycles < 10) begin
         @(negedge clk);
         wait_cycles++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
